// File: rtl/huffman_len_gen_if.sv
// Handshake bundle for huffman_len_gen: job control, frequency input stream
// and symbol/length/code output stream.
//
// master : job source / downstream sink (drives start, freq, sym_ready)
// slave  : huffman_len_gen
//   start_i       begin new job (honoured only when idle)
//   freq_valid_i  frequency word valid
//   freq_ready_o  frequency word accepted (LOAD only)
//   freq_i        frequency of next symbol, symbol 0 first
//   sym_valid_o   output record valid
//   sym_ready_i   downstream accept
//   sym_o         symbol index of record
//   len_o         code length, 0 = unused symbol
//   code_o        canonical code, right-aligned (0 when codes are not built)
//   busy_o        job in progress
//   err_len_o     sticky: some length exceeds MAX_LEN
//   done_o        one-cycle pulse after the last record is accepted
interface huffman_len_gen_if #(
   parameter int NUM_SYM    = 256,
   parameter int FREQ_WIDTH = 16,
   parameter int MAX_LEN    = 15,
   parameter int LEN_W      = $clog2(NUM_SYM) + 1
);
   localparam int SYM_W = $clog2(NUM_SYM);

   logic                  start_i;
   logic                  freq_valid_i;
   logic                  freq_ready_o;
   logic [FREQ_WIDTH-1:0] freq_i;
   logic                  sym_valid_o;
   logic                  sym_ready_i;
   logic [SYM_W-1:0]      sym_o;
   logic [LEN_W-1:0]      len_o;
   logic [MAX_LEN-1:0]    code_o;
   logic                  busy_o;
   logic                  err_len_o;
   logic                  done_o;

   modport master (
      output start_i, freq_valid_i, freq_i, sym_ready_i,
      input  freq_ready_o, sym_valid_o, sym_o, len_o, code_o,
      input  busy_o, err_len_o, done_o
   );

   modport slave (
      input  start_i, freq_valid_i, freq_i, sym_ready_i,
      output freq_ready_o, sym_valid_o, sym_o, len_o, code_o,
      output busy_o, err_len_o, done_o
   );
endinterface

// File: rtl/huffman_len_gen.sv
// Huffman code-length builder: loads NUM_SYM frequencies, builds the tree by
// repeated serial min-pair scans, derives leaf depths, then streams one
// (symbol, length, code) record per symbol.
//
// Ports: clk, rst (synchronous, active high), bus (huffman_len_gen_if.slave).
// Optional macro HUFF_CANON_CODE_EN: builds bl_count/next_code and the
// COUNT/NEXTC states so code_o carries canonical codes; otherwise code_o = 0.
module huffman_len_gen #(
   parameter int NUM_SYM    = 256,
   parameter int FREQ_WIDTH = 16,
   parameter int MAX_LEN    = 15,
   parameter int LEN_W      = $clog2(NUM_SYM) + 1
) (
   input logic clk,
   input logic rst,
   huffman_len_gen_if.slave bus
);
   localparam int SYM_W = $clog2(NUM_SYM);
   localparam int ND_W  = SYM_W + 1;
   localparam int NN    = 2 * NUM_SYM - 1;
   localparam int WT_W  = FREQ_WIDTH + SYM_W;
   localparam int KC_W  = SYM_W + 1;

   localparam logic [31:0]      MAX_LEN_U = MAX_LEN;
   localparam logic [ND_W-1:0]  LEAF_N    = ND_W'(NUM_SYM);
   localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(NUM_SYM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SCAN, S_MERGE, S_DEPTH,
`ifdef HUFF_CANON_CODE_EN
      S_COUNT, S_NEXTC,
`endif
      S_EMIT
   } state_t;

`ifdef HUFF_CANON_CODE_EN
   localparam state_t S_POSTD = S_COUNT;
`else
   localparam state_t S_POSTD = S_EMIT;
`endif

   state_t state_q, state_d;

   // Nodes 0..NUM_SYM-1 are leaves, NUM_SYM+m is the m-th merge.
   logic [WT_W-1:0]  weight [NN];
   logic [LEN_W-1:0] depth  [NN];
   logic [NN-1:0]    active;
   logic [ND_W-1:0]  child0 [NUM_SYM];
   logic [ND_W-1:0]  child1 [NUM_SYM];

   logic [SYM_W-1:0] ld_cnt, single_idx, m_cnt, d_idx, emit_idx;
   logic [KC_W-1:0]  k_cnt;
   logic [ND_W-1:0]  scan_idx, min1_idx, min2_idx;
   logic [WT_W-1:0]  min1_wt, min2_wt;
   logic             min1_vld, min2_vld;
   logic             err_q, done_q;

   logic             ld_hs, ld_nz, ld_last, merge_last, dep_long, emit_vld;
   logic [ND_W-1:0]  ld_leaf, scan_last, new_idx, dep_node;
   logic [KC_W-1:0]  k_next;
   logic [WT_W-1:0]  w_cur;
   logic [LEN_W-1:0] dep_child, emit_len;

   assign ld_hs      = bus.freq_valid_i & (state_q == S_LOAD);
   assign ld_nz      = bus.freq_i != '0;
   assign ld_last    = ld_cnt == SYM_LAST;
   assign ld_leaf    = ND_W'(ld_cnt);
   assign k_next     = k_cnt + KC_W'(ld_nz);
   assign scan_last  = LEAF_N + ND_W'(m_cnt) - ND_W'(1);
   assign new_idx    = LEAF_N + ND_W'(m_cnt);
   // m+1 == K-1: this merge produces the root
   assign merge_last = (KC_W'(m_cnt) + KC_W'(2)) == k_cnt;
   assign w_cur      = weight[scan_idx];
   assign dep_node   = LEAF_N + ND_W'(d_idx);
   assign dep_child  = depth[dep_node] + LEN_W'(1);
   // an over-deep internal node always has over-deep leaves beneath it
   assign dep_long   = {{(32-LEN_W){1'b0}}, dep_child} > MAX_LEN_U;
   assign emit_vld   = state_q == S_EMIT;
   assign emit_len   = depth[ND_W'(emit_idx)];

`ifdef HUFF_CANON_CODE_EN
   localparam int LC_W = $clog2(MAX_LEN + 1);
   localparam int CW   = MAX_LEN + KC_W + 1;

   logic [KC_W-1:0]    bl_count  [MAX_LEN+1];
   logic [MAX_LEN-1:0] next_code [MAX_LEN+1];
   logic [SYM_W-1:0]   cnt_idx;
   logic [LC_W-1:0]    nc_idx, nc_prev, cnt_sel, emit_sel;
   logic [LEN_W-1:0]   cnt_len;
   logic [CW-1:0]      nc_sum;
   logic               cnt_ok, emit_ok;
   logic [MAX_LEN-1:0] emit_code;

   assign cnt_len  = depth[ND_W'(cnt_idx)];
   assign cnt_ok   = (cnt_len != '0) &&
                     ({{(32-LEN_W){1'b0}}, cnt_len} <= MAX_LEN_U);
   assign cnt_sel  = LC_W'(cnt_len);
   assign nc_prev  = nc_idx - LC_W'(1);
   assign nc_sum   = CW'(next_code[nc_prev]) + CW'(bl_count[nc_prev]);
   assign emit_ok  = (emit_len != '0) &&
                     ({{(32-LEN_W){1'b0}}, emit_len} <= MAX_LEN_U);
   assign emit_sel = LC_W'(emit_len);
   assign emit_code = emit_ok ? next_code[emit_sel] : '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.start_i) state_d = S_LOAD;
         S_LOAD: begin
            if (ld_hs && ld_last) begin
               if (k_next == '0)              state_d = S_EMIT;
               else if (k_next == KC_W'(1))   state_d = S_POSTD;
               else                           state_d = S_SCAN;
            end
         end
         S_SCAN:  if (scan_idx == scan_last) state_d = S_MERGE;
         S_MERGE: state_d = merge_last ? S_DEPTH : S_SCAN;
         S_DEPTH: if (d_idx == '0) state_d = S_POSTD;
`ifdef HUFF_CANON_CODE_EN
         S_COUNT: if (cnt_idx == SYM_LAST) state_d = S_NEXTC;
         S_NEXTC: if (nc_idx == LC_W'(MAX_LEN)) state_d = S_EMIT;
`endif
         S_EMIT: begin
            if (bus.sym_ready_i && emit_idx == SYM_LAST)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active     <= '0;
         ld_cnt     <= '0;
         single_idx <= '0;
         k_cnt      <= '0;
         m_cnt      <= '0;
         d_idx      <= '0;
         emit_idx   <= '0;
         scan_idx   <= '0;
         min1_idx   <= '0;
         min2_idx   <= '0;
         min1_wt    <= '0;
         min2_wt    <= '0;
         min1_vld   <= 1'b0;
         min2_vld   <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  active   <= '0;
                  ld_cnt   <= '0;
                  k_cnt    <= '0;
                  m_cnt    <= '0;
                  emit_idx <= '0;
                  err_q    <= 1'b0;
               end
            end
            S_LOAD: begin
               if (ld_hs) begin
                  weight[ld_leaf] <= WT_W'(bus.freq_i);
                  active[ld_leaf] <= ld_nz;
                  depth[ld_leaf]  <= '0;
                  k_cnt           <= k_next;
                  if (ld_nz) single_idx <= ld_cnt;
                  ld_cnt   <= ld_cnt + SYM_W'(1);
                  scan_idx <= '0;
                  min1_vld <= 1'b0;
                  min2_vld <= 1'b0;
                  // lone symbol still needs a 1-bit code
                  if (ld_last && k_next == KC_W'(1))
                     depth[ld_nz ? ld_leaf : ND_W'(single_idx)] <= LEN_W'(1);
               end
            end
            S_SCAN: begin
               // strict compares keep the lower index on equal weights
               if (active[scan_idx]) begin
                  if (!min1_vld || w_cur < min1_wt) begin
                     min2_idx <= min1_idx;
                     min2_wt  <= min1_wt;
                     min2_vld <= min1_vld;
                     min1_idx <= scan_idx;
                     min1_wt  <= w_cur;
                     min1_vld <= 1'b1;
                  end else if (!min2_vld || w_cur < min2_wt) begin
                     min2_idx <= scan_idx;
                     min2_wt  <= w_cur;
                     min2_vld <= 1'b1;
                  end
               end
               scan_idx <= scan_idx + ND_W'(1);
            end
            S_MERGE: begin
               weight[new_idx]  <= min1_wt + min2_wt;
               active[min1_idx] <= 1'b0;
               active[min2_idx] <= 1'b0;
               active[new_idx]  <= 1'b1;
               child0[m_cnt]    <= min1_idx;
               child1[m_cnt]    <= min2_idx;
               m_cnt            <= m_cnt + SYM_W'(1);
               scan_idx         <= '0;
               min1_vld         <= 1'b0;
               min2_vld         <= 1'b0;
               if (merge_last) begin
                  depth[new_idx] <= '0;
                  d_idx          <= m_cnt;
               end
            end
            S_DEPTH: begin
               // parents are created after children, so walking back
               // from the root always sees the parent depth first
               depth[child0[d_idx]] <= dep_child;
               depth[child1[d_idx]] <= dep_child;
               if (dep_long) err_q <= 1'b1;
               d_idx <= d_idx - SYM_W'(1);
            end
            S_EMIT: begin
               if (bus.sym_ready_i) begin
                  emit_idx <= emit_idx + SYM_W'(1);
                  if (emit_idx == SYM_LAST) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef HUFF_CANON_CODE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_idx <= '0;
         nc_idx  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  for (int l = 0; l <= MAX_LEN; l++)
                     bl_count[LC_W'(l)] <= '0;
                  next_code[0] <= '0;
                  cnt_idx      <= '0;
               end
            end
            S_COUNT: begin
               if (cnt_ok)
                  bl_count[cnt_sel] <= bl_count[cnt_sel] + KC_W'(1);
               cnt_idx <= cnt_idx + SYM_W'(1);
               nc_idx  <= LC_W'(1);
            end
            S_NEXTC: begin
               next_code[nc_idx] <= MAX_LEN'(nc_sum << 1);
               nc_idx            <= nc_idx + LC_W'(1);
            end
            S_EMIT: begin
               if (bus.sym_ready_i && emit_ok)
                  next_code[emit_sel] <= next_code[emit_sel] + MAX_LEN'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.code_o = emit_vld ? emit_code : '0;
`else
   assign bus.code_o = '0;
`endif

   assign bus.freq_ready_o = state_q == S_LOAD;
   assign bus.sym_valid_o  = emit_vld;
   assign bus.sym_o        = emit_vld ? emit_idx : '0;
   assign bus.len_o        = emit_vld ? emit_len : '0;
   assign bus.busy_o       = state_q != S_IDLE;
   assign bus.err_len_o    = err_q;
   assign bus.done_o       = done_q;
endmodule

// File: tb/tb_huffman_len_gen.sv
// Directed bench for huffman_len_gen: two instances (MAX_LEN 15 and 3),
// stimulus routed to one at a time by sel.
module tb_huffman_len_gen;
   localparam int NS = 8;
   localparam int FW = 16;
   localparam int LW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sel, start, fvalid, sready;
   logic [FW-1:0] freq;

   huffman_len_gen_if #(.NUM_SYM(NS), .FREQ_WIDTH(FW), .MAX_LEN(15),
                        .LEN_W(LW)) if_a ();
   huffman_len_gen_if #(.NUM_SYM(NS), .FREQ_WIDTH(FW), .MAX_LEN(3),
                        .LEN_W(LW)) if_b ();

   assign if_a.start_i      = start & ~sel;
   assign if_a.freq_valid_i = fvalid & ~sel;
   assign if_a.freq_i       = freq;
   assign if_a.sym_ready_i  = sready & ~sel;
   assign if_b.start_i      = start & sel;
   assign if_b.freq_valid_i = fvalid & sel;
   assign if_b.freq_i       = freq;
   assign if_b.sym_ready_i  = sready & sel;

   huffman_len_gen #(.NUM_SYM(NS), .FREQ_WIDTH(FW), .MAX_LEN(15),
                     .LEN_W(LW)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   huffman_len_gen #(.NUM_SYM(NS), .FREQ_WIDTH(FW), .MAX_LEN(3),
                     .LEN_W(LW)) u_b (.clk(clk), .rst(rst), .bus(if_b));

   logic          fready, svalid, busy, err, done;
   logic [2:0]    sym;
   logic [LW-1:0] len;
   logic [14:0]   code;

   assign fready = sel ? if_b.freq_ready_o : if_a.freq_ready_o;
   assign svalid = sel ? if_b.sym_valid_o  : if_a.sym_valid_o;
   assign busy   = sel ? if_b.busy_o       : if_a.busy_o;
   assign err    = sel ? if_b.err_len_o    : if_a.err_len_o;
   assign done   = sel ? if_b.done_o       : if_a.done_o;
   assign sym    = sel ? if_b.sym_o        : if_a.sym_o;
   assign len    = sel ? if_b.len_o        : if_a.len_o;
   assign code   = sel ? {12'd0, if_b.code_o} : if_a.code_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int stim     [NS];
   int exp_len  [NS];
   int exp_code [NS];
   int got_sym  [NS];
   int got_len  [NS];
   int got_code [NS];
   int n_rec, done_seen, timed_out;

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_load();
      int t;
      for (int k = 0; k < NS; k++) begin
         fvalid = 1'b1;
         freq   = FW'(stim[k]);
         t = 0;
         while (!fready && t < 50) begin
            @(negedge clk);
            t++;
         end
         if (t >= 50) timed_out = 1;
         @(negedge clk);
      end
      fvalid = 1'b0;
   endtask

   task automatic collect();
      n_rec = 0;
      done_seen = 0;
      sready = 1'b1;
      for (int i = 0; i < NS; i++) begin
         got_sym[i] = -1; got_len[i] = -1; got_code[i] = -1;
      end
      for (int c = 0; c < 3000 && done_seen == 0; c++) begin
         if (done) done_seen++;
         if (svalid && sready) begin
            if (n_rec < NS) begin
               got_sym[n_rec]  = int'(sym);
               got_len[n_rec]  = int'(len);
               got_code[n_rec] = int'(code);
            end
            n_rec++;
         end
         @(negedge clk);
      end
      if (done_seen == 0) timed_out = 1;
      for (int c = 0; c < 3; c++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
   endtask

   task automatic run_job();
      timed_out = 0;
      do_start();
      do_load();
      collect();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({if_a.busy_o, if_a.freq_ready_o, if_a.sym_valid_o,
           if_a.err_len_o, if_a.done_o} !== 5'b0) begin
         $display("FAIL reset_a_flags: got %b want 00000",
                  {if_a.busy_o, if_a.freq_ready_o, if_a.sym_valid_o,
                   if_a.err_len_o, if_a.done_o});
      end else pass_cnt++;
      chk_cnt++;
      if ({if_a.sym_o, if_a.len_o, if_a.code_o} !== '0) begin
         $display("FAIL reset_a_data: got %h want 0",
                  {if_a.sym_o, if_a.len_o, if_a.code_o});
      end else pass_cnt++;
      chk_cnt++;
      if ({if_b.busy_o, if_b.sym_valid_o, if_b.err_len_o,
           if_b.done_o, if_b.code_o} !== '0) begin
         $display("FAIL reset_b: got %h want 0",
                  {if_b.busy_o, if_b.sym_valid_o, if_b.err_len_o,
                   if_b.done_o, if_b.code_o});
      end else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_idle_busy: got %b want 0", busy);
      end else pass_cnt++;
   endtask

   task automatic test_basic(input string name);
      stim = '{5, 9, 12, 13, 16, 45, 0, 0};
      exp_len = '{4, 4, 3, 3, 3, 1, 0, 0};
`ifdef HUFF_CANON_CODE_EN
      exp_code = '{14, 15, 4, 5, 6, 0, 0, 0};
`else
      exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
      run_job();
      chk_cnt++;
      if (timed_out !== 0 || n_rec !== NS) begin
         $display("FAIL %s records: got %0d (timeout %0d) want %0d",
                  name, n_rec, timed_out, NS);
      end else pass_cnt++;
      for (int i = 0; i < NS; i++) begin
         chk_cnt++;
         if (got_sym[i] !== i || got_len[i] !== exp_len[i]) begin
            $display("FAIL %s len[%0d]: got sym %0d len %0d want %0d",
                     name, i, got_sym[i], got_len[i], exp_len[i]);
         end else pass_cnt++;
         chk_cnt++;
         if (got_code[i] !== exp_code[i]) begin
            $display("FAIL %s code[%0d]: got %0d want %0d",
                     name, i, got_code[i], exp_code[i]);
         end else pass_cnt++;
      end
      chk_cnt++;
      if (done_seen !== 1 || err !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL %s end: got done %0d err %b busy %b want 1 0 0",
                  name, done_seen, err, busy);
      end else pass_cnt++;
   endtask

   task automatic test_single();
      stim = '{0, 0, 0, 7, 0, 0, 0, 0};
      run_job();
      chk_cnt++;
      if (timed_out !== 0 || n_rec !== NS || done_seen !== 1) begin
         $display("FAIL single_flow: got n %0d done %0d to %0d want 8 1 0",
                  n_rec, done_seen, timed_out);
      end else pass_cnt++;
      for (int i = 0; i < NS; i++) begin
         chk_cnt++;
         if (got_len[i] !== ((i == 3) ? 1 : 0) || got_code[i] !== 0) begin
            $display("FAIL single[%0d]: got len %0d code %0d want %0d 0",
                     i, got_len[i], got_code[i], (i == 3) ? 1 : 0);
         end else pass_cnt++;
      end
   endtask

   task automatic test_all_zero();
      stim = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_job();
      chk_cnt++;
      if (timed_out !== 0 || n_rec !== NS || done_seen !== 1 ||
          err !== 1'b0) begin
         $display("FAIL zero_flow: got n %0d done %0d err %b want 8 1 0",
                  n_rec, done_seen, err);
      end else pass_cnt++;
      for (int i = 0; i < NS; i++) begin
         chk_cnt++;
         if (got_sym[i] !== i || got_len[i] !== 0 || got_code[i] !== 0) begin
            $display("FAIL zero[%0d]: got sym %0d len %0d code %0d want %0d 0 0",
                     i, got_sym[i], got_len[i], got_code[i], i);
         end else pass_cnt++;
      end
   endtask

   task automatic test_len_limit();
      sel = 1'b1;
      stim = '{1, 1, 2, 4, 8, 16, 32, 64};
      exp_len = '{7, 7, 6, 5, 4, 3, 2, 1};
`ifdef HUFF_CANON_CODE_EN
      exp_code = '{0, 0, 0, 0, 0, 6, 2, 0};
`else
      exp_code = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
      run_job();
      for (int i = 0; i < NS; i++) begin
         chk_cnt++;
         if (got_len[i] !== exp_len[i] || got_code[i] !== exp_code[i]) begin
            $display("FAIL limit[%0d]: got len %0d code %0d want %0d %0d",
                     i, got_len[i], got_code[i], exp_len[i], exp_code[i]);
         end else pass_cnt++;
      end
      repeat (5) @(negedge clk);
      chk_cnt++;
      if (err !== 1'b1 || done_seen !== 1 || timed_out !== 0) begin
         $display("FAIL limit_err_sticky: got err %b done %0d want 1 1",
                  err, done_seen);
      end else pass_cnt++;
      timed_out = 0;
      do_start();
      chk_cnt++;
      if (err !== 1'b0 || fready !== 1'b1) begin
         $display("FAIL limit_err_clear: got err %b ready %b want 0 1",
                  err, fready);
      end else pass_cnt++;
      stim = '{0, 0, 0, 0, 0, 0, 0, 0};
      do_load();
      collect();
      chk_cnt++;
      if (err !== 1'b0 || done_seen !== 1 || timed_out !== 0) begin
         $display("FAIL limit_next_job: got err %b done %0d want 0 1",
                  err, done_seen);
      end else pass_cnt++;
      sel = 1'b0;
   endtask

   task automatic test_back_pressure();
      int held;
      int exp2;
`ifdef HUFF_CANON_CODE_EN
      exp2 = 4;
`else
      exp2 = 0;
`endif
      stim = '{5, 9, 12, 13, 16, 45, 0, 0};
      timed_out = 0;
      do_start();
      do_load();
      n_rec = 0;
      done_seen = 0;
      held = 0;
      sready = 1'b1;
      for (int i = 0; i < NS; i++) got_sym[i] = -1;
      for (int c = 0; c < 3000 && done_seen == 0; c++) begin
         if (done) done_seen++;
         if (svalid && sym == 3'd2 && held == 0) begin
            sready = 1'b0;
            for (int h = 0; h < 3; h++) begin
               @(negedge clk);
               chk_cnt++;
               if (svalid !== 1'b1 || sym !== 3'd2 || len !== LW'(3) ||
                   code !== 15'(exp2)) begin
                  $display("FAIL hold_stable[%0d]: got v %b sym %0d len %0d code %0d want 1 2 3 %0d",
                           h, svalid, sym, len, code, exp2);
               end else pass_cnt++;
            end
            held = 1;
            sready = 1'b1;
         end
         if (svalid && sready) begin
            if (n_rec < NS) got_sym[n_rec] = int'(sym);
            n_rec++;
         end
         @(negedge clk);
      end
      chk_cnt++;
      if (n_rec !== NS || done_seen !== 1 || held !== 1) begin
         $display("FAIL hold_count: got n %0d done %0d held %0d want 8 1 1",
                  n_rec, done_seen, held);
      end else pass_cnt++;
      for (int i = 0; i < NS; i++) begin
         chk_cnt++;
         if (got_sym[i] !== i) begin
            $display("FAIL hold_order[%0d]: got %0d want %0d",
                     i, got_sym[i], i);
         end else pass_cnt++;
      end
   endtask

   task automatic test_abort();
      int dn;
      stim = '{5, 9, 12, 13, 16, 45, 0, 0};
      timed_out = 0;
      do_start();
      do_load();
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (busy !== 1'b1 || fready !== 1'b0 || svalid !== 1'b0) begin
         $display("FAIL abort_in_scan: got busy %b rdy %b v %b want 1 0 0",
                  busy, fready, svalid);
      end else pass_cnt++;
      rst = 1'b1;
      dn = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) dn++;
      end
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk_cnt++;
      if (busy !== 1'b0 || dn !== 0) begin
         $display("FAIL abort_quiet: got busy %b done pulses %0d want 0 0",
                  busy, dn);
      end else pass_cnt++;
      test_basic("after_abort");
   endtask

   initial begin
      rst = 1'b1;
      sel = 1'b0;
      start = 1'b0;
      fvalid = 1'b0;
      sready = 1'b0;
      freq = '0;
      test_reset();
      test_basic("basic");
      test_single();
      test_all_zero();
      test_len_limit();
      test_back_pressure();
      test_abort();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
